// File: rtl/tblink_rpc_pkg.sv
// tblink_rpc_pkg: shared constants, FSM encodings and error-bit indices for the tblink RPC host peer
package tblink_rpc_pkg;
    localparam logic [7:0] CMD_RSP  = 8'h00;
    localparam logic [7:0] DST_HOST = 8'h00;
    localparam int ERR_UNEXP = 0;
    localparam int ERR_ID    = 1;
    localparam int ERR_SIZE  = 2;
    typedef enum logic [2:0] {TX_IDLE, TX_SZ, TX_CMD, TX_ID, TX_DAT} tx_state_t;
    typedef enum logic [2:0] {RX_DST, RX_SZ, RX_CMD, RX_ID, RX_DAT, RX_HOLD} rx_state_t;
endpackage

// File: rtl/tblink_rpc_frame_rx.sv
// tblink_rpc_frame_rx: parses DST/SZ/CMD/ID/payload frames and holds each one until it is accepted
module tblink_rpc_frame_rx import tblink_rpc_pkg::*; #(
    parameter int PAYLOAD_SZ = 4
) (
    input  logic                    uclock,
    input  logic                    reset,
    input  logic [7:0]              rx_dat,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic                    outstanding,
    input  logic [7:0]              last_id,
    input  logic                    ack,
    output logic                    frm_valid,
    output logic [7:0]              frm_cmd,
    output logic [7:0]              frm_id,
    output logic [7:0]              frm_sz,
    output logic [8*PAYLOAD_SZ-1:0] frm_data,
    output logic [2:0]              err_set
);
    localparam logic [7:0] PSZ = 8'(PAYLOAD_SZ);

    rx_state_t state, next;
    logic [7:0] cnt, idx, n, id_now;
    logic beat, last, keep;

    assign rx_ready  = state != RX_HOLD;
    assign frm_valid = state == RX_HOLD;
    assign beat      = rx_valid && rx_ready;
    assign last      = beat && ((state == RX_ID && cnt == 8'd0) || (state == RX_DAT && cnt == 8'd1));
    assign keep      = frm_cmd != CMD_RSP || outstanding;
    assign n         = rx_dat == 8'd0 ? 8'd0 : rx_dat - 8'd1;
    assign id_now    = state == RX_ID ? rx_dat : frm_id;

    // State register; reset abandons any partially received frame
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) state <= RX_DST;
        else       state <= next;
    end

    // Next state: the frame ends on the ID byte when empty, otherwise on the last payload byte
    always_comb begin
        next = state;
        case (state)
            RX_DST:        if (beat) next = RX_SZ;
            RX_SZ:         if (beat) next = RX_CMD;
            RX_CMD:        if (beat) next = RX_ID;
            RX_ID, RX_DAT: if (last) next = keep ? RX_HOLD : RX_DST; else if (beat) next = RX_DAT;
            RX_HOLD:       if (ack) next = RX_DST;
            default:       next = RX_DST;
        endcase
    end

    // Error events: bad/oversize size, unsolicited response, response ID not matching the request
    always_comb begin
        err_set = '0;
        err_set[ERR_SIZE]  = beat && ((state == RX_SZ && rx_dat == 8'd0) || (state == RX_DAT && idx >= PSZ));
        err_set[ERR_UNEXP] = last && frm_cmd == CMD_RSP && !outstanding;
        err_set[ERR_ID]    = last && frm_cmd == CMD_RSP && outstanding && id_now != last_id;
    end

    // Header capture and payload placement; bytes beyond the payload buffer are dropped
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            idx      <= '0;
            frm_cmd  <= '0;
            frm_id   <= '0;
            frm_sz   <= '0;
            frm_data <= '0;
        end else if (beat) begin
            if (state == RX_SZ) begin
                cnt      <= n;
                idx      <= '0;
                frm_sz   <= n > PSZ ? PSZ : n;
                frm_data <= '0;
            end
            if (state == RX_CMD) frm_cmd <= rx_dat;
            if (state == RX_ID) frm_id <= rx_dat;
            if (state == RX_DAT) begin
                for (int k = 0; k < PAYLOAD_SZ; k++)
                    if (idx == 8'(k)) frm_data[8*k +: 8] <= rx_dat;
                idx <= idx + 8'd1;
                cnt <= cnt - 8'd1;
            end
        end
    end
endmodule

// File: rtl/tblink_rpc_hostproc.sv
// tblink_rpc_hostproc: host-side RPC peer; frames requests/answers out, routes parsed frames in
module tblink_rpc_hostproc import tblink_rpc_pkg::*; #(
    parameter int PAYLOAD_SZ = 4
) (
    input  logic                    uclock,
    input  logic                    reset,
    output logic [7:0]              tx_dat,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [7:0]              rx_dat,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic [7:0]              req_cmd,
    input  logic [7:0]              req_sz,
    input  logic [8*PAYLOAD_SZ-1:0] req_params,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic [7:0]              rsp_id,
    output logic [7:0]              rsp_sz,
    output logic [8*PAYLOAD_SZ-1:0] rsp_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [7:0]              dreq_cmd,
    output logic [7:0]              dreq_id,
    output logic [7:0]              dreq_sz,
    output logic [8*PAYLOAD_SZ-1:0] dreq_params,
    output logic                    dreq_valid,
    input  logic                    dreq_ready,
    input  logic [7:0]              drsp_sz,
    input  logic [8*PAYLOAD_SZ-1:0] drsp_data,
    input  logic                    drsp_valid,
    output logic                    drsp_ready,
    output logic [2:0]              err
);
    localparam logic [7:0] PSZ = 8'(PAYLOAD_SZ);

    tx_state_t tx_state, tx_next;
    logic [7:0] lat_sz, lat_cmd, lat_id, cnt, next_id, last_id, dreq_id_q, sz_in, frm_cmd, frm_id, frm_sz;
    logic [8*PAYLOAD_SZ-1:0] lat_data, frm_data;
    logic [2:0] rx_err, tx_err;
    logic outstanding, dreq_taken, lat_is_req, take_drsp, take_req, tx_beat, tx_done, frm_valid, frm_ack;

    tblink_rpc_frame_rx #(.PAYLOAD_SZ(PAYLOAD_SZ)) u_rx (
        .uclock(uclock), .reset(reset), .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .outstanding(outstanding), .last_id(last_id), .ack(frm_ack), .frm_valid(frm_valid),
        .frm_cmd(frm_cmd), .frm_id(frm_id), .frm_sz(frm_sz), .frm_data(frm_data), .err_set(rx_err)
    );

    assign rsp_valid   = frm_valid && frm_cmd == CMD_RSP;
    assign dreq_valid  = frm_valid && frm_cmd != CMD_RSP;
    assign rsp_id      = frm_id;
    assign rsp_sz      = frm_sz;
    assign rsp_data    = frm_data;
    assign dreq_cmd    = frm_cmd;
    assign dreq_id     = frm_id;
    assign dreq_sz     = frm_sz;
    assign dreq_params = frm_data;
    assign frm_ack     = (rsp_valid && rsp_ready) || (dreq_valid && dreq_ready);

    assign drsp_ready = tx_state == TX_IDLE && dreq_taken;
    assign req_ready  = tx_state == TX_IDLE && !outstanding && !drsp_valid;
    assign take_drsp  = drsp_valid && drsp_ready;
    assign take_req   = req_valid && req_ready;
    assign sz_in      = take_drsp ? drsp_sz : req_sz;
    assign tx_valid   = tx_state != TX_IDLE;
    assign tx_beat    = tx_valid && tx_ready;
    assign tx_done    = tx_beat && ((tx_state == TX_ID && lat_sz == 8'd0) || (tx_state == TX_DAT && cnt == 8'd1));
    assign tx_dat     = tx_state == TX_SZ  ? lat_sz + 8'd1 :
                        tx_state == TX_CMD ? lat_cmd :
                        tx_state == TX_ID  ? lat_id :
                        tx_state == TX_DAT ? lat_data[7:0] : 8'h00;

    // Oversize outgoing payloads are clamped and flagged at acceptance
    always_comb begin
        tx_err = '0;
        tx_err[ERR_SIZE] = (take_drsp || take_req) && sz_in > PSZ;
    end

    // TX state register; reset drops the frame in flight
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next state: one header/payload byte per accepted beat, frames never interleave
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (take_drsp || take_req) tx_next = TX_SZ;
            TX_SZ:   if (tx_ready) tx_next = TX_CMD;
            TX_CMD:  if (tx_ready) tx_next = TX_ID;
            TX_ID:   if (tx_ready) tx_next = lat_sz == 8'd0 ? TX_IDLE : TX_DAT;
            TX_DAT:  if (tx_ready && cnt == 8'd1) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // Latch the winning input, shift payload out, track request IDs, pairing state and sticky errors
    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            lat_sz      <= '0;
            lat_cmd     <= '0;
            lat_id      <= '0;
            lat_data    <= '0;
            lat_is_req  <= 1'b0;
            cnt         <= '0;
            next_id     <= '0;
            last_id     <= '0;
            dreq_id_q   <= '0;
            outstanding <= 1'b0;
            dreq_taken  <= 1'b0;
            err         <= '0;
        end else begin
            if (take_drsp || take_req) begin
                lat_sz     <= sz_in > PSZ ? PSZ : sz_in;
                cnt        <= sz_in > PSZ ? PSZ : sz_in;
                lat_cmd    <= take_drsp ? CMD_RSP : req_cmd;
                lat_id     <= take_drsp ? dreq_id_q : next_id;
                lat_data   <= take_drsp ? drsp_data : req_params;
                lat_is_req <= take_req;
            end
            if (tx_beat && tx_state == TX_DAT) begin
                lat_data <= lat_data >> 8;
                cnt      <= cnt - 8'd1;
            end
            if (rsp_valid && rsp_ready) outstanding <= 1'b0;
            if (tx_done && lat_is_req) begin
                next_id     <= next_id + 8'd1;
                last_id     <= lat_id;
                outstanding <= 1'b1;
            end
            if (dreq_valid && dreq_ready) begin
                dreq_taken <= 1'b1;
                dreq_id_q  <= dreq_id;
            end
            if (take_drsp) dreq_taken <= 1'b0;
            err <= err | rx_err | tx_err;
        end
    end
endmodule

// File: tb/tb_tblink_rpc_hostproc.sv
// tb_tblink_rpc_hostproc: table-driven frame vectors plus priority and mid-frame reset sequences
module tb_tblink_rpc_hostproc;
    localparam int P = 4;

    logic uclock = 1'b0, reset = 1'b1;
    logic [7:0] tx_dat, rx_dat = '0, req_cmd = '0, req_sz = '0, rsp_id, rsp_sz;
    logic [7:0] dreq_cmd, dreq_id, dreq_sz, drsp_sz = '0;
    logic [8*P-1:0] req_params = '0, rsp_data, dreq_params, drsp_data = '0;
    logic tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready, req_valid = 1'b0, req_ready;
    logic rsp_valid, rsp_ready = 1'b0, dreq_valid, dreq_ready = 1'b0, drsp_valid = 1'b0, drsp_ready;
    logic [2:0] err;

    int checks = 0, errors = 0;
    bit stall = 1'b0;

    typedef struct {
        int          mode;
        bit          stall;
        logic [7:0]  cmd, sz;
        logic [31:0] pl;
        logic [63:0] tx;
        int          tx_n;
        logic [79:0] rx;
        int          rx_n;
        logic [7:0]  e_cmd, e_id, e_sz;
        logic [31:0] e_data;
        logic [2:0]  e_err;
    } vec_t;

    always #5 uclock = ~uclock;

    tblink_rpc_hostproc #(.PAYLOAD_SZ(P)) dut (
        .uclock(uclock), .reset(reset),
        .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .req_cmd(req_cmd), .req_sz(req_sz), .req_params(req_params), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_id(rsp_id), .rsp_sz(rsp_sz), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .dreq_cmd(dreq_cmd), .dreq_id(dreq_id), .dreq_sz(dreq_sz), .dreq_params(dreq_params),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready),
        .drsp_sz(drsp_sz), .drsp_data(drsp_data), .drsp_valid(drsp_valid), .drsp_ready(drsp_ready),
        .err(err)
    );

    function automatic vec_t mk(input int mode, input bit st, input logic [7:0] cmd, sz, input logic [31:0] pl,
                                input logic [63:0] tx, input int tx_n, input logic [79:0] rx, input int rx_n,
                                input logic [7:0] e_cmd, e_id, e_sz, input logic [31:0] e_data, input logic [2:0] e_err);
        vec_t v;
        v.mode = mode; v.stall = st; v.cmd = cmd; v.sz = sz; v.pl = pl; v.tx = tx; v.tx_n = tx_n;
        v.rx = rx; v.rx_n = rx_n; v.e_cmd = e_cmd; v.e_id = e_id; v.e_sz = e_sz; v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] c, input logic [7:0] s, input logic [31:0] p, input string tag);
        int t = 0;
        req_cmd = c; req_sz = s; req_params = p; req_valid = 1'b1; #1;
        while (!req_ready && t < 100) begin @(negedge uclock); #1; t++; end
        chk({tag, " req handshake"}, 32'(t < 100), 1);
        @(negedge uclock);
        req_valid = 1'b0;
    endtask

    task automatic send_drsp(input logic [7:0] s, input logic [31:0] p, input string tag);
        int t = 0;
        drsp_sz = s; drsp_data = p; drsp_valid = 1'b1; #1;
        while (!drsp_ready && t < 100) begin @(negedge uclock); #1; t++; end
        chk({tag, " drsp handshake"}, 32'(t < 100), 1);
        @(negedge uclock);
        drsp_valid = 1'b0;
    endtask

    task automatic expect_tx(input logic [63:0] f, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            bit got = 1'b0;
            while (!got && t < 200) begin
                tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1; #1;
                if (tx_valid && tx_ready) begin
                    chk($sformatf("%s tx byte %0d", tag, k), 32'(tx_dat), 32'(f[8*k +: 8]));
                    got = 1'b1;
                end
                @(negedge uclock);
                t++;
            end
            chk($sformatf("%s tx byte %0d arrived", tag, k), 32'(got), 1);
        end
        tx_ready = 1'b0; #1;
        chk({tag, " tx idle after frame"}, 32'(tx_valid), 0);
    endtask

    task automatic send_rx(input logic [79:0] f, input int n, input string tag);
        bit ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            int t = 0;
            if (stall) repeat ($urandom_range(0, 2)) begin rx_valid = 1'b0; @(negedge uclock); end
            rx_dat = f[8*k +: 8]; rx_valid = 1'b1; #1;
            while (!rx_ready && t < 50) begin @(negedge uclock); #1; t++; end
            if (t >= 50) ok = 1'b0;
            @(negedge uclock);
        end
        rx_valid = 1'b0;
        chk({tag, " rx accepted"}, 32'(ok), 1);
        #1;
    endtask

    task automatic run_vec(input int i, input vec_t x);
        string tag = $sformatf("v%0d", i);
        stall = x.stall;
        if (x.mode == 0) begin
            send_req(x.cmd, x.sz, x.pl, tag);
            expect_tx(x.tx, x.tx_n, tag);
            chk({tag, " req_ready while outstanding"}, 32'(req_ready), 0);
            send_rx(x.rx, x.rx_n, tag);
            chk({tag, " rsp_valid"}, 32'(rsp_valid), 1);
            chk({tag, " rsp_id"}, 32'(rsp_id), 32'(x.e_id));
            chk({tag, " rsp_sz"}, 32'(rsp_sz), 32'(x.e_sz));
            chk({tag, " rsp_data"}, rsp_data, x.e_data);
            rsp_ready = 1'b1; @(negedge uclock); rsp_ready = 1'b0; #1;
            chk({tag, " rsp_valid after handshake"}, 32'(rsp_valid), 0);
            chk({tag, " req_ready after response"}, 32'(req_ready), 1);
        end else if (x.mode == 1) begin
            send_rx(x.rx, x.rx_n, tag);
            chk({tag, " dreq_valid"}, 32'(dreq_valid), 1);
            chk({tag, " dreq_cmd"}, 32'(dreq_cmd), 32'(x.e_cmd));
            chk({tag, " dreq_id"}, 32'(dreq_id), 32'(x.e_id));
            chk({tag, " dreq_sz"}, 32'(dreq_sz), 32'(x.e_sz));
            chk({tag, " dreq_params"}, dreq_params, x.e_data);
            dreq_ready = 1'b1; @(negedge uclock); dreq_ready = 1'b0; #1;
            chk({tag, " dreq_valid after handshake"}, 32'(dreq_valid), 0);
            send_drsp(x.sz, x.pl, tag);
            expect_tx(x.tx, x.tx_n, tag);
        end else begin
            send_rx(x.rx, x.rx_n, tag);
            chk({tag, " no rsp_valid"}, 32'(rsp_valid), 0);
            chk({tag, " no dreq_valid"}, 32'(dreq_valid), 0);
            chk({tag, " rx_ready"}, 32'(rx_ready), 1);
        end
        chk({tag, " err"}, 32'(err), 32'(x.e_err));
        stall = 1'b0;
    endtask

    initial begin
        vec_t v[8];
        v[0] = mk(0, 0, 8'h05, 8'd2, 32'h0000BBAA, 64'hBB_AA_00_05_03, 5, 80'h22_11_00_00_03_00, 6, 8'h00, 8'h00, 8'd2, 32'h00002211, 3'b000);
        v[1] = mk(1, 0, 8'h00, 8'd1, 32'h00000044, 64'h44_09_00_02, 4, 80'h09_07_01_00, 4, 8'h07, 8'h09, 8'd0, 32'h0, 3'b000);
        v[2] = mk(2, 0, 8'h00, 8'd0, 32'h0, 64'h0, 0, 80'h05_00_01_00, 4, 8'h00, 8'h00, 8'd0, 32'h0, 3'b001);
        v[3] = mk(0, 0, 8'h21, 8'd0, 32'h0, 64'h01_21_01, 3, 80'h01_00_01_00, 4, 8'h00, 8'h01, 8'd0, 32'h0, 3'b001);
        v[4] = mk(1, 1, 8'h00, 8'd6, 32'h44332211, 64'h44_33_22_11_44_00_05, 7, 80'hA1_A0_44_33_03_00, 6, 8'h33, 8'h44, 8'd2, 32'h0000A1A0, 3'b101);
        v[5] = mk(0, 0, 8'h10, 8'd4, 32'hDDCCBBAA, 64'hDD_CC_BB_AA_02_10_05, 7, 80'hE1_07_00_02_00, 5, 8'h00, 8'h07, 8'd1, 32'h000000E1, 3'b111);
        v[6] = mk(1, 1, 8'h00, 8'd2, 32'h0000BEEF, 64'hBE_EF_44_00_03, 5, 80'hA5_A4_A3_A2_A1_A0_44_33_07_00, 10, 8'h33, 8'h44, 8'd4, 32'hA3A2A1A0, 3'b100);
        v[7] = mk(0, 1, 8'h05, 8'd2, 32'h0000BBAA, 64'hBB_AA_00_05_03, 5, 80'h22_11_00_00_03_00, 6, 8'h00, 8'h00, 8'd2, 32'h00002211, 3'b100);

        repeat (2) @(negedge uclock);
        reset = 1'b0; #1;
        chk("reset tx_valid", 32'(tx_valid), 0);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset dreq_valid", 32'(dreq_valid), 0);
        chk("reset drsp_ready", 32'(drsp_ready), 0);
        chk("reset err", 32'(err), 0);
        chk("reset req_ready", 32'(req_ready), 1);
        @(negedge uclock);

        for (int i = 0; i < 6; i++) run_vec(i, v[i]);

        send_rx(80'h0D_0C_01_00, 4, "prio");
        chk("prio dreq_id", 32'(dreq_id), 32'h0D);
        dreq_ready = 1'b1; @(negedge uclock); dreq_ready = 1'b0;
        req_cmd = 8'h42; req_sz = 8'd0; req_params = '0; req_valid = 1'b1;
        drsp_sz = 8'd0; drsp_data = '0; drsp_valid = 1'b1; #1;
        chk("prio drsp_ready", 32'(drsp_ready), 1);
        chk("prio req_ready blocked", 32'(req_ready), 0);
        @(negedge uclock);
        drsp_valid = 1'b0;
        expect_tx(64'h0D_00_01, 3, "prio drsp");
        send_req(8'h42, 8'd0, 32'h0, "prio");
        expect_tx(64'h03_42_01, 3, "prio req");
        send_rx(80'h03_00_01_00, 4, "prio");
        chk("prio rsp_valid", 32'(rsp_valid), 1);
        chk("prio rsp_id", 32'(rsp_id), 32'h03);
        rsp_ready = 1'b1; @(negedge uclock); rsp_ready = 1'b0;

        send_req(8'h55, 8'd3, 32'h00332211, "rst");
        tx_ready = 1'b1;
        repeat (2) @(negedge uclock);
        #1 reset = 1'b1;
        @(negedge uclock);
        chk("rst tx_valid", 32'(tx_valid), 0);
        chk("rst err", 32'(err), 0);
        chk("rst req_ready", 32'(req_ready), 1);
        tx_ready = 1'b0;
        reset = 1'b0;
        @(negedge uclock);

        for (int i = 6; i < 8; i++) run_vec(i, v[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
